// File: rtl/ysyx22041405_pkg.sv
// ---------------------------------------------------------------------------
// ysyx22041405_pkg
// Shared definitions for the writeback unit: load-size encodings, pending
// counter width, register-file geometry and the writeback control payload.
// ---------------------------------------------------------------------------
package ysyx22041405_pkg;

  // Register-file geometry
  localparam int unsigned RA_W   = 5;
  localparam int unsigned NREG   = 32;

  // Pending-write counter per architectural register
  localparam int unsigned CNT_W  = 2;

  typedef logic [CNT_W-1:0] pcnt_t;

  localparam pcnt_t CNT_ZERO = '0;
  localparam pcnt_t CNT_ONE  = pcnt_t'(1);
  localparam pcnt_t CNT_MAX  = '1;

  // Load access size, as carried on in_ld_size
  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } ld_size_e;

  // Control half of the writeback register
  typedef struct packed {
    logic            wen;
    logic [RA_W-1:0] rd;
  } wb_ctl_t;

endpackage : ysyx22041405_pkg

// File: rtl/ysyx22041405_ld_ext.sv
// ---------------------------------------------------------------------------
// ysyx22041405_ld_ext
// Combinational load-data extraction: picks the addressed byte or halfword
// out of the raw memory word and sign/zero extends it. Non-loads and word
// loads pass the input through unchanged.
//   is_load     : result comes from a load
//   size        : ld_size_e encoding (byte / half / word)
//   ld_unsigned : zero-extend instead of sign-extend
//   addr_lo     : byte address bits [1:0]
//   res         : ALU result or raw memory word
//   data_c      : value to be written back
// ---------------------------------------------------------------------------
module ysyx22041405_ld_ext
  import ysyx22041405_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_load,
  input  logic [1:0]       size,
  input  logic             ld_unsigned,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  // Lane selection; halfword uses addr_lo[1] only
  always_comb begin
    byte_sel = res[7:0];
    case (addr_lo)
      2'd0:    byte_sel = res[7:0];
      2'd1:    byte_sel = res[15:8];
      2'd2:    byte_sel = res[23:16];
      default: byte_sel = res[31:24];
    endcase
    half_sel  = addr_lo[1] ? res[31:16] : res[15:0];
    byte_sign = byte_sel[7] & ~ld_unsigned;
    half_sign = half_sel[15] & ~ld_unsigned;
  end

  // Extension; unknown size encodings behave as a word load
  always_comb begin
    data_c = res;
    if (is_load) begin
      case (ld_size_e'(size))
        LD_BYTE: data_c = {{(WIDTH-8){byte_sign}}, byte_sel};
        LD_HALF: data_c = {{(WIDTH-16){half_sign}}, half_sel};
        default: data_c = res;
      endcase
    end
  end

endmodule : ysyx22041405_ld_ext

// File: rtl/ysyx22041405_wbu.sv
// ---------------------------------------------------------------------------
// ysyx22041405_wbu
// Writeback unit: one-entry writeback register feeding the regfile write
// port, retire reporting, and a per-register pending-write scoreboard used
// by the IDU for hazard detection and issue throttling.
//   clk, rst                    : clock, async active-high reset
//   iss_valid/iss_wen/iss_rd    : instruction issue from IDU
//   iss_ready                   : issue accepted (scoreboard not saturated)
//   in_valid/in_ready           : EXU/LSU result handshake
//   in_wen/in_rd                : result write enable and destination
//   in_is_load/in_ld_size/
//   in_ld_unsigned/in_addr_lo   : load extraction controls
//   in_res/in_pc                : result or raw memory word; instruction PC
//   rf_we/rf_waddr/rf_wdata     : regfile write port
//   q_raddr1/q_raddr2/hazard    : IDU source query and pending-write flag
//   commit_valid/pc/cnt         : retire pulse, retired PC, retired count
//   sb_err                      : sticky scoreboard underflow
// ---------------------------------------------------------------------------
module ysyx22041405_wbu
  import ysyx22041405_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             iss_valid,
  input  logic             iss_wen,
  input  logic [RA_W-1:0]  iss_rd,
  output logic             iss_ready,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wen,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_is_load,
  input  logic [1:0]       in_ld_size,
  input  logic             in_ld_unsigned,
  input  logic [1:0]       in_addr_lo,
  input  logic [WIDTH-1:0] in_res,
  input  logic [WIDTH-1:0] in_pc,

  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,

  input  logic [RA_W-1:0]  q_raddr1,
  input  logic [RA_W-1:0]  q_raddr2,
  output logic             hazard,

  output logic             commit_valid,
  output logic [WIDTH-1:0] commit_pc,
  output logic [63:0]      commit_cnt,
  output logic             sb_err
);

  // Writeback register
  logic             wb_valid;
  wb_ctl_t          wb_ctl;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] wb_pc;

  // Scoreboard
  pcnt_t [NREG-1:0] pend_q;
  pcnt_t [NREG-1:0] pend_d;
  logic             inc_c;
  logic             dec_hits_iss_c;
  logic             underflow_c;

  logic [WIDTH-1:0] ld_data_c;
  logic             accept_c;

  // Load data is extracted before it is registered
  ysyx22041405_ld_ext #(
    .WIDTH(WIDTH)
  ) u_ld_ext (
    .is_load     (in_is_load),
    .size        (in_ld_size),
    .ld_unsigned (in_ld_unsigned),
    .addr_lo     (in_addr_lo),
    .res         (in_res),
    .data_c      (ld_data_c)
  );

  // Single-entry register never stalls; only reset holds it off
  assign in_ready = ~rst;
  assign accept_c = in_valid & in_ready;

  // Regfile port and retire report straight from the registered fields
  assign rf_we        = wb_valid & wb_ctl.wen & (wb_ctl.rd != '0);
  assign rf_waddr     = wb_ctl.rd;
  assign rf_wdata     = wb_data;
  assign commit_valid = wb_valid;
  assign commit_pc    = wb_pc;

  // Hazard sees the counters as they stand; a write this cycle is not bypassed
  assign hazard = ((q_raddr1 != '0) && (pend_q[q_raddr1] != CNT_ZERO)) ||
                  ((q_raddr2 != '0) && (pend_q[q_raddr2] != CNT_ZERO));

  // Scoreboard next state and issue throttle
  always_comb begin
    pend_d         = pend_q;
    underflow_c    = 1'b0;
    dec_hits_iss_c = rf_we && (rf_waddr == iss_rd);
    // A saturated counter may still accept when the same register retires now
    iss_ready      = !(iss_wen && (iss_rd != '0) &&
                       (pend_q[iss_rd] == CNT_MAX) && !dec_hits_iss_c);
    inc_c          = iss_valid && iss_ready && iss_wen && (iss_rd != '0);

    // Increment and decrement of the same register cancel out
    if (!(inc_c && dec_hits_iss_c)) begin
      if (inc_c) begin
        pend_d[iss_rd] = pend_q[iss_rd] + CNT_ONE;
      end
      if (rf_we) begin
        if (pend_q[rf_waddr] == CNT_ZERO) begin
          underflow_c = 1'b1;
        end else begin
          pend_d[rf_waddr] = pend_q[rf_waddr] - CNT_ONE;
        end
      end
    end
    pend_d[0] = CNT_ZERO;
  end

  // Writeback register capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_ctl   <= '0;
      wb_data  <= '0;
      wb_pc    <= '0;
    end else begin
      wb_valid <= accept_c;
      if (accept_c) begin
        wb_ctl.wen <= in_wen;
        wb_ctl.rd  <= in_rd;
        wb_data    <= ld_data_c;
        wb_pc      <= in_pc;
      end
    end
  end

  // Scoreboard, retire counter and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      commit_cnt <= '0;
      sb_err     <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wb_valid) begin
        commit_cnt <= commit_cnt + 64'd1;
      end
      if (underflow_c) begin
        sb_err <= 1'b1;
      end
    end
  end

endmodule : ysyx22041405_wbu

// File: tb/tb_ysyx22041405_wbu.sv
// ---------------------------------------------------------------------------
// tb_ysyx22041405_wbu
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a behavioural model of pending writes, retirement and load data.
// ---------------------------------------------------------------------------
module tb_ysyx22041405_wbu;

  logic        clk;
  logic        rst;
  logic        iss_valid, iss_wen, iss_ready;
  logic [4:0]  iss_rd;
  logic        in_valid, in_ready, in_wen;
  logic [4:0]  in_rd;
  logic        in_is_load, in_ld_unsigned;
  logic [1:0]  in_ld_size, in_addr_lo;
  logic [31:0] in_res, in_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_raddr1, q_raddr2;
  logic        hazard;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [63:0] commit_cnt;
  logic        sb_err;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int          pend [32];
  bit          m_err;
  longint      m_cnt;
  bit          wv, ww;
  logic [4:0]  wrd;
  logic [31:0] wd, wp;

  ysyx22041405_wbu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_rd(in_rd),
    .in_is_load(in_is_load), .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_addr_lo(in_addr_lo), .in_res(in_res), .in_pc(in_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2), .hazard(hazard),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_cnt(commit_cnt),
    .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Load result from the architectural definition of lb/lh/lw and unsigned forms
  function automatic logic [31:0] ld_model(input logic [31:0] res, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] lo);
    longint v;
    if (sz == 2'd0) begin
      v = longint'((res >> (int'(lo) * 8)) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((res >> (lo[1] ? 16 : 0)) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(res);
    end
    return v[31:0];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_err = 0; m_cnt = 0; wv = 0; ww = 0; wrd = '0; wd = '0; wp = '0;
  endtask

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_rd = '0;
    in_valid = 0; in_wen = 0; in_rd = '0; in_is_load = 0; in_ld_size = '0;
    in_ld_unsigned = 0; in_addr_lo = '0; in_res = '0; in_pc = '0;
    q_raddr1 = '0; q_raddr2 = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1; iss_wen = 1; iss_rd = rd;
  endtask

  task automatic result(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
    in_valid = 1; in_wen = 1; in_rd = rd; in_res = res; in_pc = pc; in_is_load = 0;
  endtask

  // Check all outputs against the model for the current inputs, then advance one clock
  task automatic tick();
    bit m_rfwe, m_ready, m_haz, inc, dec;
    #1;
    m_rfwe  = wv && ww && (wrd != 0);
    m_ready = !(iss_wen && iss_rd != 0 && pend[iss_rd] == 3 && !(m_rfwe && wrd == iss_rd));
    m_haz   = (q_raddr1 != 0 && pend[q_raddr1] != 0) || (q_raddr2 != 0 && pend[q_raddr2] != 0);
    chk("rf_we", 64'(rf_we), 64'(m_rfwe));
    if (m_rfwe) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(wrd));
      chk("rf_wdata", 64'(rf_wdata), 64'(wd));
    end
    chk("commit_valid", 64'(commit_valid), 64'(wv));
    if (wv) chk("commit_pc", 64'(commit_pc), 64'(wp));
    chk("commit_cnt", commit_cnt, 64'(m_cnt));
    chk("sb_err", 64'(sb_err), 64'(m_err));
    chk("iss_ready", 64'(iss_ready), 64'(m_ready));
    chk("hazard", 64'(hazard), 64'(m_haz));
    chk("in_ready", 64'(in_ready), 64'd1);

    inc = iss_valid && m_ready && iss_wen && iss_rd != 0;
    dec = m_rfwe;
    if (!(inc && dec && iss_rd == wrd)) begin
      if (inc) pend[iss_rd] = pend[iss_rd] + 1;
      if (dec) begin
        if (pend[wrd] == 0) m_err = 1;
        else pend[wrd] = pend[wrd] - 1;
      end
    end
    if (wv) m_cnt = m_cnt + 1;
    wv  = in_valid;
    ww  = in_wen;
    wrd = in_rd;
    wd  = in_is_load ? ld_model(in_res, in_ld_size, in_ld_unsigned, in_addr_lo) : in_res;
    wp  = in_pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 6));
  endfunction

  longint cnt_before;

  initial begin
    idle();
    mreset();
    rst = 0;
    #1 rst = 1;
    #2;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_iss_ready", 64'(iss_ready), 64'd1);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // lb with sign extension from the top byte
    idle(); issue(5'd4); tick();
    idle(); result(5'd4, 32'h80FF_7F01, 32'h100);
    in_is_load = 1; in_ld_size = 2'b00; in_ld_unsigned = 0; in_addr_lo = 2'd3;
    tick();
    idle(); #1;
    chk("lb_wdata", 64'(rf_wdata), 64'h0000_0000_FFFF_FF80);
    chk("lb_we", 64'(rf_we), 64'd1);
    tick();

    // lhu from the upper halfword
    idle(); issue(5'd6); tick();
    idle(); result(5'd6, 32'h8001_1234, 32'h104);
    in_is_load = 1; in_ld_size = 2'b01; in_ld_unsigned = 1; in_addr_lo = 2'd2;
    tick();
    idle(); #1;
    chk("lhu_wdata", 64'(rf_wdata), 64'h0000_8001);
    tick();

    // Hazard on x5 persists through the write cycle, clears after it
    idle(); issue(5'd5); q_raddr1 = 5'd5; tick();
    idle(); q_raddr1 = 5'd5; #1;
    chk("haz_pending", 64'(hazard), 64'd1);
    result(5'd5, 32'h55, 32'h108); tick();
    idle(); q_raddr1 = 5'd5; #1;
    chk("haz_write_cycle", 64'(hazard), 64'd1);
    chk("haz_rf_we", 64'(rf_we), 64'd1);
    tick();
    idle(); q_raddr1 = 5'd5; #1;
    chk("haz_cleared", 64'(hazard), 64'd0);
    tick();

    // Saturate x7, then release with a same-cycle write
    for (int i = 0; i < 3; i++) begin idle(); issue(5'd7); tick(); end
    idle(); issue(5'd7); #1;
    chk("sat_ready", 64'(iss_ready), 64'd0);
    tick();
    idle(); result(5'd7, 32'h77, 32'h10C); tick();
    idle(); issue(5'd7); #1;
    chk("sat_same_cycle_ready", 64'(iss_ready), 64'd1);
    chk("sat_same_cycle_we", 64'(rf_we), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin idle(); result(5'd7, 32'(i), 32'h110); tick(); end
    idle(); tick();

    // Underflow on x3 is sticky; x0 writes retire without writing
    idle(); result(5'd3, 32'h33, 32'h200); tick();
    idle(); tick();
    idle(); #1;
    chk("underflow_err", 64'(sb_err), 64'd1);
    tick();
    idle(); tick();
    idle(); #1;
    chk("underflow_sticky", 64'(sb_err), 64'd1);
    cnt_before = m_cnt;
    result(5'd0, 32'hDEAD, 32'h204); tick();
    idle(); #1;
    chk("x0_rf_we", 64'(rf_we), 64'd0);
    chk("x0_commit", 64'(commit_valid), 64'd1);
    tick();
    idle(); #1;
    chk("x0_commit_cnt", commit_cnt, 64'(cnt_before + 1));
    tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      iss_valid      = 1'($urandom_range(0, 1));
      iss_wen        = ($urandom_range(0, 3) != 0);
      iss_rd         = pick();
      in_valid       = 1'($urandom_range(0, 1));
      in_wen         = ($urandom_range(0, 3) != 0);
      in_rd          = pick();
      in_is_load     = 1'($urandom_range(0, 1));
      in_ld_size     = 2'($urandom_range(0, 2));
      in_ld_unsigned = 1'($urandom_range(0, 1));
      in_addr_lo     = 2'($urandom_range(0, 3));
      in_res         = $urandom;
      in_pc          = $urandom;
      q_raddr1       = pick();
      q_raddr2       = pick();
      tick();
    end

    // Reset asserted mid-cycle with a writeback in flight
    idle(); issue(5'd9); tick();
    idle(); result(5'd9, 32'h99, 32'h300); tick();
    idle(); issue(5'd9); q_raddr1 = 5'd9; #1;
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    rst = 1;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_commit", 64'(commit_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_iss_ready", 64'(iss_ready), 64'd1);
    chk("mid_rst_hazard", 64'(hazard), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    mreset();
    idle(); q_raddr1 = 5'd9; q_raddr2 = 5'd7; #1;
    chk("post_rst_cnt", commit_cnt, 64'd0);
    chk("post_rst_hazard", 64'(hazard), 64'd0);
    chk("post_rst_err", 64'(sb_err), 64'd0);
    tick();
    idle(); issue(5'd9); tick();
    idle(); q_raddr1 = 5'd9; tick();
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ysyx22041405_wbu

// File: doc/ysyx22041405_wbu.md
YSYX22041405_WBU -- requirements
Module: ysyx22041405_wbu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width; load extraction is defined for WIDTH=32 only.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port iss_valid  input  1  IDU issues an instruction this cycle.
REQ-005 SHALL have port iss_wen  input  1  the issued instruction writes a register.
REQ-006 SHALL have port iss_rd  input  5  destination register of the issued instruction.
REQ-007 SHALL have port iss_ready  output  1  the issue can be accepted (scoreboard not saturated).
REQ-008 SHALL have port in_valid  input  1  EXU/LSU result valid.
REQ-009 SHALL have port in_ready  output  1  writeback register can accept a result.
REQ-010 SHALL have port in_wen, in_rd  input  1, 5  write enable and destination of the result.
REQ-011 SHALL have port in_is_load, in_ld_size, in_ld_unsigned, in_addr_lo  input  1, 2, 1, 2  load flags, size (00 byte, 01 half, 10 word), zero-extend, address bits [1:0].
REQ-012 SHALL have port in_res, in_pc  input  WIDTH each  ALU result or raw memory word; instruction PC.
REQ-013 SHALL have port rf_we, rf_waddr, rf_wdata  output  1, 5, WIDTH  regfile write port.
REQ-014 SHALL have port q_raddr1, q_raddr2  input  5 each  IDU source registers under query.
REQ-015 SHALL have port hazard  output  1  a queried source has a pending write.
REQ-016 SHALL have port commit_valid, commit_pc, commit_cnt  output  1, WIDTH, 64  retire pulse, retired PC, total retired count.
REQ-017 SHALL have port sb_err  output  1  sticky scoreboard underflow flag.

Function
REQ-018 SHALL hold one writeback register (valid + fields); a result is captured when in_valid && in_ready; in_ready SHALL be 1 whenever rst is low.
REQ-019 SHALL drive rf_we = wb_valid && wb_wen && wb_rd!=0, rf_waddr = wb_rd, and rf_wdata from the registered fields; latency input handshake to regfile write = 1 cycle.
REQ-020 SHALL, for loads, select byte in_res[8*addr_lo+:8], half by addr_lo[1] (addr_lo[0] ignored), word unchanged; sign-extend unless ld_unsigned; extraction is done before registering.
REQ-021 SHALL pulse commit_valid for every wb_valid cycle (writing or not) with commit_pc = wb_pc, and increment commit_cnt by 1 in that same edge.
REQ-022 SHALL keep a 2-bit pending counter per register 1..31; register 0 is never tracked and always reads 0.
REQ-023 SHALL increment cnt[iss_rd] on iss_valid && iss_ready && iss_wen && iss_rd!=0, and decrement cnt[rf_waddr] when rf_we.
REQ-024 SHALL leave a counter unchanged when increment and decrement hit the same register in the same cycle.
REQ-025 SHALL drive iss_ready = 0 only when iss_wen, iss_rd!=0, cnt[iss_rd]==3 and no same-cycle decrement of iss_rd.
REQ-026 SHALL, on a decrement of a zero counter, keep the counter at 0 and set sb_err until reset.
REQ-027 SHALL drive hazard = (q_raddr1!=0 && cnt[q_raddr1]!=0) || (q_raddr2!=0 && cnt[q_raddr2]!=0), combinationally, with no bypass of the write occurring this cycle.

Reset
REQ-028 SHALL, while rst is high, asynchronously clear wb_valid, all counters, commit_cnt and sb_err; rf_we, commit_valid, hazard SHALL be 0, in_ready 0, iss_ready 1.
REQ-029 SHALL discard any in-flight writeback on reset assertion mid-operation; no regfile write occurs in the reset cycle.

Structure
REQ-030 SHALL take load-size encodings and the counter width from shared package ysyx22041405_pkg.
REQ-031 SHALL place load extraction in combinational sub-module ysyx22041405_ld_ext.

Verification
REQ-032 SHALL test: lb, in_res=0x80FF_7F01, addr_lo=3 -> next cycle rf_wdata=0xFFFF_FF80, rf_we=1.
REQ-033 SHALL test: lhu, in_res=0x8001_1234, addr_lo=2 -> rf_wdata=0x0000_8001.
REQ-034 SHALL test: issue rd=5, query q_raddr1=5 -> hazard=1 until the cycle after rd=5 write, then 0.
REQ-035 SHALL test: three issues to rd=7 without writeback -> iss_ready=0 for a fourth; same-cycle write to x7 -> iss_ready=1.
REQ-036 SHALL test: writeback to x3 with cnt[3]=0 -> sb_err=1 sticky; write with in_rd=0 -> rf_we=0, commit_valid=1, commit_cnt+1.
REQ-037 SHALL test: rst asserted mid-cycle with wb_valid=1 -> rf_we drops immediately, counters and commit_cnt read 0 after release.
